store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Parametrised committed-store buffer between the pipeline's execute stage and the data-memory write port.
//  Generalises the single-entry store->load forward to a DEPTH-entry FIFO.
//  Drains stores to memory under a ready handshake.
//  Forwards the youngest matching store to loads in the same cycle.
//  Coalesces back-to-back stores to the same word.
// PARAMETERS
//  ADDR_W  16  byte-address width; word index = addr[ADDR_W-1:1]
//  DATA_W  16  store data width (one memory word)
//  DEPTH   4   entry count; power of 2, >=2; pointers are $clog2(DEPTH) bits
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           asynchronous reset, active-high
//  st_valid   in   1           committed store presented this cycle
//  st_addr    in   ADDR_W      store byte address (bit 0 ignored)
//  st_data    in   DATA_W      store data
//  st_ready   out  1           buffer accepts the store this cycle (comb.)
//  ld_valid   in   1           load lookup request
//  ld_addr    in   ADDR_W      load byte address (bit 0 ignored)
//  ld_hit     out  1           a buffered store matches ld_addr (comb.)
//  ld_data    out  DATA_W      data of youngest matching entry (0 if !ld_hit)
//  mem_wen    out  1           head entry presented to memory
//  mem_waddr  out  ADDR_W-1    head word address (addr[ADDR_W-1:1])
//  mem_wdata  out  DATA_W      head data
//  mem_ready  in   1           memory takes the write at this edge
//  count      out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
//  empty      out  1           count==0
//  overflow   out  1           sticky: store offered while !st_ready
// BEHAVIOUR
//  Reset (async, rst=1):
//   - head=tail=count=0; mem_wen=0, ld_hit=0, overflow=0, empty=1, st_ready=1.
//   - Entry payloads are not reset.
//   - Reset mid-drain discards every pending store; no further mem_wen until a new store is pushed.
//  Pop:
//   - pop = mem_wen & mem_ready; mem_wen = (count!=0).
//   - Head advances mod DEPTH at the edge.
//   - mem_waddr/mem_wdata hold steady while mem_wen & !mem_ready.
//  Coalesce:
//   - coal = st_valid & count!=0 & word(st_addr)==youngest entry word & !(count==1 & pop).
//   - On coal: data of the youngest entry is overwritten at the edge; tail and count are unchanged.
//  Push:
//   - push = st_valid & st_ready & !coal.
//   - Writes the entry at tail; tail advances mod DEPTH.
//  st_ready = (count<DEPTH) | coal. A full buffer does not accept a new word in the cycle it pops.
//  count update: count + push - pop. Push and pop in the same cycle leave count unchanged.
//  overflow: set at the edge when st_valid & !st_ready; the store is dropped. Cleared only by rst.
//  Latency:
//   - A store accepted at edge N gives mem_wen=1 and forwarding visibility from cycle N+1.
//   - A new store is not forwarded to a load in the same cycle.
//  Forwarding:
//   - Compare ld_addr against every occupied entry; the youngest match (nearest tail) wins.
//   - ld_hit requires ld_valid.
//   - The entry being popped this cycle is still visible to ld.
//  Ordering: memory sees stores in program order, except that coalesced stores to one word collapse into a single write.
//  Comparison uses word address only; ADDR_W-1 bits; no carry/width extension anywhere.
// TESTING (DEPTH=4)
//  1. rst mid-op:
//     - Setup: 3 stores queued, mem_ready=0; assert rst.
//     - Required: count=0, empty=1, mem_wen=0 immediately (async).
//     - Then mem_ready=1 for 5 cycles -> no writes.
//  2. Fill/full:
//     - Setup: mem_ready=0; stores to 0x10,0x20,0x30,0x40 -> count=4, st_ready=0.
//     - Store to 0x50 -> dropped, overflow=1.
//     - Then mem_ready=1 -> writes 0x08,0x10,0x18,0x20 (word addr) in order, one per cycle; empty=1 after the 4th.
//  3. Coalesce:
//     - Setup: mem_ready=0; st 0x22=0xAAAA then st 0x23=0xBBBB.
//     - Required: count=1; drain writes word 0x11=0xBBBB once.
//     - Repeat with count==1 & pop in the same cycle -> two writes, 0xAAAA then 0xBBBB.
//  4. Forwarding:
//     - Setup: st 0x40=0x1111, st 0x60=0x2222, st 0x40=0x3333 (non-adjacent, no coalesce).
//     - ld 0x40 -> ld_hit=1, ld_data=0x3333; ld 0x50 -> ld_hit=0, ld_data=0.
//     - ld 0x40 in the same cycle as st 0x40 to an empty buffer -> ld_hit=0.
//  5. Wrap/simultaneous:
//     - Setup: mem_ready=1; 10 back-to-back stores to distinct words.
//     - Required: count stays 1 after the first and all 10 writes appear in order.
//     - Then stall mem_ready for 1 cycle -> count=2 and mem_waddr held.

Source files
------------

// File: rtl/store_buffer.sv
// Committed-store FIFO between execute and the data-memory write port.
// Drains in order under mem_ready, forwards the youngest matching store to loads, coalesces same-word stores.
module store_buffer #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   output logic                     st_ready,
   input  logic                     ld_valid,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic                     ld_hit,
   output logic [DATA_W-1:0]        ld_data,
   output logic                     mem_wen,
   output logic [ADDR_W-2:0]        mem_waddr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WA_W  = ADDR_W - 1;

   logic [WA_W-1:0]   word_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [PTR_W-1:0]  young_idx;
   logic [CNT_W-1:0]  count_q;
   logic              ovf_q;

   logic [WA_W-1:0]   st_word;
   logic [WA_W-1:0]   ld_word;
   logic              pop;
   logic              coal;
   logic              push;
   logic              full;
   logic              unused_addr_lsb;

   // Byte-offset bit is irrelevant: everything works on word addresses.
   assign st_word         = st_addr[ADDR_W-1:1];
   assign ld_word         = ld_addr[ADDR_W-1:1];
   assign unused_addr_lsb = st_addr[0] ^ ld_addr[0];

   assign young_idx = tail_q - PTR_W'(1);
   assign full      = (count_q == CNT_W'(DEPTH));

   assign mem_wen   = (count_q != '0);
   assign mem_waddr = word_q[head_q];
   assign mem_wdata = data_q[head_q];
   assign pop       = mem_wen & mem_ready;

   // A lone entry leaving this cycle can no longer absorb a store; it becomes a fresh push.
   assign coal     = st_valid & (count_q != '0) & (st_word == word_q[young_idx])
                     & ~((count_q == CNT_W'(1)) & pop);
   assign st_ready = ~full | coal;
   assign push     = st_valid & st_ready & ~coal;

   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign overflow = ovf_q;

   // Scan oldest to youngest so the last match (nearest tail) wins.
   always_comb begin
      ld_hit  = 1'b0;
      ld_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ld_valid && (CNT_W'(i) < count_q)
             && (word_q[PTR_W'(head_q + PTR_W'(i))] == ld_word)) begin
            ld_hit  = 1'b1;
            ld_data = data_q[PTR_W'(head_q + PTR_W'(i))];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (st_valid && !st_ready) ovf_q <= 1'b1;
      end
   end

   // Payload storage carries no reset; occupancy alone qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         word_q[tail_q] <= st_word;
         data_q[tail_q] <= st_data;
      end else if (coal) begin
         data_q[young_idx] <= st_data;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a queue-based reference model.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [15:0] st_addr;
   logic [15:0] st_data;
   logic        st_ready;
   logic        ld_valid;
   logic [15:0] ld_addr;
   logic        ld_hit;
   logic [15:0] ld_data;
   logic        mem_wen;
   logic [14:0] mem_waddr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [2:0]  count;
   logic        empty;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   // Reference model: pending stores oldest-first, plus sticky overflow.
   logic [14:0] mq_w[$];
   logic [15:0] mq_d[$];
   logic        m_ovf;
   logic [31:0] wr_log[$];

   logic [31:0] obs_cnt, obs_hit, obs_ldata, obs_waddr, obs_ovf, obs_empty;

   store_buffer #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .count(count), .empty(empty), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, compare just after, advance model at posedge.
   task automatic step(input logic stv, input logic [15:0] sta, input logic [15:0] std,
                       input logic ldv, input logic [15:0] lda, input logic mr);
      int          sz;
      logic        pop, coal, rdy, push, ehit;
      logic [15:0] eld;
      @(negedge clk);
      st_valid = stv; st_addr = sta; st_data = std;
      ld_valid = ldv; ld_addr = lda; mem_ready = mr;
      #1;
      sz   = mq_w.size();
      pop  = (sz != 0) && mr;
      coal = stv && (sz != 0) && (sta[15:1] == mq_w[sz-1]) && !(sz == 1 && pop);
      rdy  = (sz < DEPTH) || coal;
      push = stv && rdy && !coal;
      ehit = 1'b0;
      eld  = 16'h0;
      if (ldv) begin
         for (int i = sz - 1; i >= 0; i--) begin
            if (!ehit && mq_w[i] == lda[15:1]) begin
               ehit = 1'b1;
               eld  = mq_d[i];
            end
         end
      end
      chk("st_ready", 32'(st_ready), 32'(rdy));
      chk("ld_hit",   32'(ld_hit),   32'(ehit));
      chk("ld_data",  32'(ld_data),  32'(eld));
      chk("mem_wen",  32'(mem_wen),  32'(sz != 0));
      if (sz != 0) begin
         chk("mem_waddr", 32'(mem_waddr), 32'(mq_w[0]));
         chk("mem_wdata", 32'(mem_wdata), 32'(mq_d[0]));
      end
      chk("count",    32'(count),    32'(sz));
      chk("empty",    32'(empty),    32'(sz == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      obs_cnt = 32'(count); obs_hit = 32'(ld_hit); obs_ldata = 32'(ld_data);
      obs_waddr = 32'(mem_waddr); obs_ovf = 32'(overflow); obs_empty = 32'(empty);
      if (mem_wen && mem_ready) wr_log.push_back({1'b0, mem_waddr, mem_wdata});
      if (stv && !rdy) m_ovf = 1'b1;
      if (coal) mq_d[sz-1] = std;
      if (pop) begin
         void'(mq_w.pop_front());
         void'(mq_d.pop_front());
      end
      if (push) begin
         mq_w.push_back(sta[15:1]);
         mq_d.push_back(std);
      end
      @(posedge clk);
   endtask

   task automatic idle(input logic mr, input int n);
      for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, mr);
   endtask

   // Asynchronous reset raised between edges; outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 16'h0100;
      rst = 1'b1;
      #1;
      chk("rst_count",    32'(count),    32'd0);
      chk("rst_empty",    32'(empty),    32'd1);
      chk("rst_mem_wen",  32'(mem_wen),  32'd0);
      chk("rst_ld_hit",   32'(ld_hit),   32'd0);
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      chk("rst_overflow", 32'(overflow), 32'd0);
      mq_w.delete(); mq_d.delete(); m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
      ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0; m_ovf = 1'b0;
      do_reset();

      // Reset in the middle of a stalled drain discards everything.
      step(1'b1, 16'h0100, 16'h0001, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0200, 16'h0002, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0300, 16'h0003, 1'b0, 16'h0, 1'b0);
      do_reset();
      wr_log.delete();
      idle(1'b1, 5);
      chk("rst_no_writes", 32'(wr_log.size()), 32'd0);

      // Fill to full, overflow on the fifth, then drain in order.
      step(1'b1, 16'h0010, 16'hA010, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0020, 16'hA020, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0030, 16'hA030, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0040, 16'hA040, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0050, 16'hA050, 1'b0, 16'h0, 1'b0);
      chk("full_count", obs_cnt, 32'd4);
      wr_log.delete();
      idle(1'b1, 5);
      chk("overflow_sticky", obs_ovf, 32'd1);
      chk("drain_empty", obs_empty, 32'd1);
      chk("drain_n", 32'(wr_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         chk("drain_order", wr_log[i] >> 16, 32'(8 * (i + 1)));

      // Same-word stores collapse into one write.
      wr_log.delete();
      step(1'b1, 16'h0022, 16'hAAAA, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0023, 16'hBBBB, 1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
      chk("coal_count", obs_cnt, 32'd1);
      idle(1'b1, 2);
      chk("coal_n", 32'(wr_log.size()), 32'd1);
      if (wr_log.size() > 0) chk("coal_wr", wr_log[0], 32'h0011_BBBB);

      // Sole entry popping this cycle cannot coalesce.
      wr_log.delete();
      step(1'b1, 16'h0022, 16'hAAAA, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0023, 16'hBBBB, 1'b0, 16'h0, 1'b1);
      idle(1'b1, 2);
      chk("nocoal_n", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() > 1) begin
         chk("nocoal_wr0", wr_log[0], 32'h0011_AAAA);
         chk("nocoal_wr1", wr_log[1], 32'h0011_BBBB);
      end

      // Forwarding picks the youngest match.
      step(1'b1, 16'h0040, 16'h1111, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0060, 16'h2222, 1'b0, 16'h0, 1'b0);
      step(1'b1, 16'h0040, 16'h3333, 1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0040, 1'b0);
      chk("fwd_hit", obs_hit, 32'd1);
      chk("fwd_data", obs_ldata, 32'h3333);
      step(1'b0, 16'h0, 16'h0, 1'b1, 16'h0050, 1'b0);
      chk("fwd_miss_hit", obs_hit, 32'd0);
      chk("fwd_miss_data", obs_ldata, 32'd0);
      idle(1'b1, 4);
      step(1'b1, 16'h0040, 16'h5555, 1'b1, 16'h0040, 1'b1);
      chk("fwd_same_cycle", obs_hit, 32'd0);
      idle(1'b1, 2);

      // Simultaneous push/pop through several wraps, then one stall.
      wr_log.delete();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 16'(16'h1000 + 4 * i), 16'(16'hC000 + i), 1'b0, 16'h0, 1'b1);
         if (i > 0) chk("wrap_count", obs_cnt, 32'd1);
      end
      step(1'b1, 16'h2000, 16'hD000, 1'b0, 16'h0, 1'b0);
      chk("stall_waddr0", obs_waddr, 32'h812);
      step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
      chk("stall_count", obs_cnt, 32'd2);
      chk("stall_waddr_held", obs_waddr, 32'h812);
      idle(1'b1, 3);
      chk("wrap_n", 32'(wr_log.size()), 32'd11);
      for (int i = 0; i < 10 && i < wr_log.size(); i++)
         chk("wrap_order", wr_log[i], {1'b0, 15'(15'h800 + 2 * i), 16'(16'hC000 + i)});

      // Random traffic on a small address window to exercise coalesce, forward and full.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)),
              16'(16'h0040 + $urandom_range(0, 7)),
              16'($urandom),
              1'($urandom_range(0, 1)),
              16'(16'h0040 + $urandom_range(0, 7)),
              1'($urandom_range(0, 2) == 0));
      end
      idle(1'b1, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
